test_i5187: RTL and testbench
=============================

# test_i5187

Serial pattern-trigger stage that sits directly downstream of the `test_I5073` subcircuit and consumes its registered output `I5073` as a one-bit stream. It shifts in qualified samples, detects a fixed bit pattern, counts matches, and raises a sticky trigger once the match count reaches a threshold. This sequential payload is the consumer half of the Nt-node benchmark pair used for trojan-detection training data.

## Interface
- `PAT_W`, default 4: pattern length in bits; legal range 2..8.
- `PATTERN`, default 4'b1011: bit sequence to detect, MSB = oldest sample.
- `THRESH`, default 3: match count that fires the trigger; legal range 1..15.
- `CW`, derived as $clog2(THRESH+1), value 2 at defaults: counter width.
- `I1470`, input, 1: clock; all flops update on the rising edge.
- `I1477`, input, 1: reset; synchronous, active-high.
- `I5073`, input, 1: serial data bit from the upstream subcircuit.
- `I5500`, input, 1: sample enable; `I5073` is shifted in only on cycles where this is 1.
- `I5521`, input, 1: clear; synchronous, clears the counter and the trigger but keeps the shift register.
- `I5590`, output, 1: match pulse, 1 cycle wide.
- `I5612`, output, 1: sticky trigger.
- `I5630`, output, CW: current match count, saturating.

## Operation
- Shift register `sr[PAT_W-1:0]`.
  - On `I5500`=1: `sr <= {sr[PAT_W-2:0], I5073}`.
  - Otherwise `sr` holds.
- Fill counter `fill`, 0..PAT_W.
  - Increments on each enabled sample and saturates at PAT_W.
  - Matching is inhibited until `fill` has reached PAT_W, so no false match on the reset-zero contents.
- Match condition: an enabled sample whose new `sr` value equals PATTERN, with `fill` already at PAT_W or reaching PAT_W on this sample.
  - On that edge `I5590` <= 1. Otherwise `I5590` <= 0.
- Overlapping matches count. For example, 1011011 with PATTERN 1011 gives 2 matches.
- FSM states:
  - IDLE: count = 0. A match moves to ARMED with count = 1. If THRESH = 1, a match moves directly to FIRED.
  - ARMED: each match increments count. When count reaches THRESH, the state moves to FIRED.
  - FIRED: `I5612` = 1. count holds at THRESH and further matches do not change it. `I5590` still pulses on matches.
- Clear (`I5521`=1):
  - Next state is IDLE, count = 0, `I5612` = 0.
  - `sr` and `fill` are unaffected.
  - Clear wins over a match on the same cycle; `I5590` still pulses for that match.
- Reset (`I1477`=1), including mid-operation:
  - Next edge: `sr` = 0, `fill` = 0, state IDLE, all outputs 0.
  - Reset overrides enable, clear and any match.

## Timing
- Reset values: `I5590` = 0, `I5612` = 0, `I5630` = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Match latency: `I5590` is high in the cycle after the edge that sampled the last pattern bit.
- `I5630` updates on the same edge as `I5590`.
- `I5612` rises on the same edge that `I5630` reaches THRESH.
- Gaps in `I5500` stretch the stream without breaking it. Pattern bits need not be on consecutive clocks, only on consecutive enabled samples.
- The upstream `I5073` is already a flop output. It is sampled directly, with no extra synchroniser.
- Throughput: one sample per clock.

## Structure
- Package `test_i5187_pkg`:
  - state enum `{IDLE, ARMED, FIRED}`, 2 bits.
  - default PATTERN, PAT_W and THRESH constants.
  - function `cw_of(thresh)`.
- Sub-module `test_i5187_shreg` contains `sr`, `fill` and the match compare.
  - Its output is a registered-input-qualified match strobe.
- The top level holds the FSM, the counter and the output registers.

## Test plan
- Reset then fill: reset 2 cycles, then enable with bits 0,0,0,0. Expect no `I5590` pulse (`sr` = 0000 ≠ 1011). Also check that all outputs are 0 during reset.
- Single match: after reset, enable with 1,0,1,1. Expect `I5590` pulse one cycle after the 4th sample, `I5630` = 1, `I5612` = 0.
- Overlap to trigger: stream 1011011011. Expect 3 pulses, `I5630` = 3, and `I5612` = 1 on the third pulse's edge. Further 011 gives a pulse with count held at 3.
- Enable gaps: send 1,0,1,1 with `I5500` low for 2 cycles between each bit. Expect exactly 1 match.
- Clear/match collision: with count = 2, assert `I5521` on the cycle the completing sample is taken. Expect `I5590` = 1, `I5630` = 0, `I5612` = 0. The next 011 gives count = 1.
- Reset mid-run: in FIRED, assert `I1477` for 1 cycle alongside a completing sample. Expect all outputs 0 next cycle, then 3 fresh samples 0,1,1 produce no match because `fill` was cleared.

Source files
------------

// File: rtl/test_i5187_pkg.sv
// -----------------------------------------------------------------------------
// test_i5187_pkg
// Shared definitions for the serial pattern-trigger stage:
//   - state_t      : trigger FSM states (IDLE, ARMED, FIRED), 2 bits
//   - DEF_PAT_W    : default pattern length in bits
//   - DEF_PATTERN  : default pattern, MSB = oldest sample
//   - DEF_THRESH   : default match count that fires the trigger
//   - cw_of()      : width of a counter able to hold 0..thresh
// -----------------------------------------------------------------------------
package test_i5187_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_THRESH  = 3;

    // A counter that must reach exactly thresh needs enough bits for 0..thresh.
    function automatic int cw_of(input int thresh);
        return $clog2(thresh + 1);
    endfunction

endpackage

// File: rtl/test_i5187_shreg.sv
// -----------------------------------------------------------------------------
// test_i5187_shreg
// Sample shift register, fill tracker and pattern compare.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (clears sr and fill)
//   en_i    : sample enable; data_i is shifted in only when high
//   data_i  : serial data bit
//   match_o : high during the cycle whose enabled sample completes the
//             pattern; built from the registered sr/fill plus the incoming
//             sample, so the parent registers it to get the match pulse
// -----------------------------------------------------------------------------
module test_i5187_shreg
    import test_i5187_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic data_i,
    output logic match_o
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

    logic [PAT_W-1:0] sr_q, sr_d;
    logic [FW-1:0]    fill_q, fill_d;

    // Next-state of the shift register and the saturating fill counter.
    // The match looks at the post-shift values so that a sample which both
    // completes the fill and the pattern is recognised on the same edge,
    // while the reset-zero contents can never produce a false match.
    always_comb begin
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_o = 1'b0;
        if (en_i) begin
            sr_d = {sr_q[PAT_W-2:0], data_i};
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FW'(1);
            end
            match_o = (sr_d == PATTERN) && (fill_d == FILL_FULL);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/test_i5187.sv
// -----------------------------------------------------------------------------
// test_i5187
// Serial pattern-trigger stage fed by the upstream I5073 flop output.
// Counts (overlapping) pattern matches and raises a sticky trigger once the
// count reaches THRESH.
// Ports:
//   I1470 : clock, rising edge
//   I1477 : synchronous active-high reset
//   I5073 : serial data bit
//   I5500 : sample enable
//   I5521 : synchronous clear of counter and trigger (shift register kept)
//   I5590 : registered match pulse, one cycle wide
//   I5612 : registered sticky trigger
//   I5630 : registered saturating match count
// -----------------------------------------------------------------------------
module test_i5187
    import test_i5187_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               THRESH  = DEF_THRESH,
    parameter int               CW      = cw_of(THRESH)
) (
    input  logic          I1470,
    input  logic          I1477,
    input  logic          I5073,
    input  logic          I5500,
    input  logic          I5521,
    output logic          I5590,
    output logic          I5612,
    output logic [CW-1:0] I5630
);

    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    logic          match;
    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          pulse_q;
    logic          trig_q;

    test_i5187_shreg #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_shreg (
        .clk_i   (I1470),
        .rst_i   (I1477),
        .en_i    (I5500),
        .data_i  (I5073),
        .match_o (match)
    );

    // Trigger FSM and match counter. Clear takes priority over a match on
    // the same cycle; the match pulse itself is unaffected by clear.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (I5521) begin
            state_d = IDLE;
            count_d = '0;
        end else if (match) begin
            case (state_q)
                IDLE: begin
                    count_d = CW'(1);
                    state_d = (THRESH == 1) ? FIRED : ARMED;
                end
                ARMED: begin
                    count_d = count_q + CW'(1);
                    if (count_d == THRESH_C) begin
                        state_d = FIRED;
                    end
                end
                FIRED: begin
                    count_d = count_q;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Output registers; the trigger is registered from the next state so it
    // rises on the same edge the count reaches THRESH.
    always_ff @(posedge I1470) begin
        if (I1477) begin
            state_q <= IDLE;
            count_q <= '0;
            pulse_q <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pulse_q <= match;
            trig_q  <= (state_d == FIRED);
        end
    end

    assign I5590 = pulse_q;
    assign I5612 = trig_q;
    assign I5630 = count_q;

endmodule

// File: tb/tb_test_i5187.sv
// -----------------------------------------------------------------------------
// tb_test_i5187
// Self-checking bench for test_i5187 with default parameters. A history-based
// model (list of enabled samples since reset, integer match count) predicts
// every output each cycle; literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_test_i5187;

    localparam int PAT_W_T  = 4;
    localparam int PAT_T    = 11;  // 1011
    localparam int THRESH_T = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic       pulseOut;
    logic       trigOut;
    logic [1:0] countOut;

    int checks    = 0;
    int errors    = 0;
    int pulseSeen = 0;

    // Model state
    bit hist[$];
    int expCount = 0;
    bit expTrig  = 1'b0;
    bit expPulse = 1'b0;

    test_i5187 dut (
        .I1470 (clk),
        .I1477 (rst),
        .I5073 (din),
        .I5500 (en),
        .I5521 (clr),
        .I5590 (pulseOut),
        .I5612 (trigOut),
        .I5630 (countOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model step: what the outputs must be after the coming edge.
    task automatic modelStep(input bit r, input bit e, input bit d, input bit c);
        int v;
        bit m;
        if (r) begin
            hist.delete();
            expCount = 0;
            expTrig  = 1'b0;
            expPulse = 1'b0;
        end else begin
            m = 1'b0;
            if (e) begin
                hist.push_back(d);
                if (hist.size() > PAT_W_T) void'(hist.pop_front());
                if (hist.size() == PAT_W_T) begin
                    v = 0;
                    foreach (hist[i]) v = (v << 1) | int'(hist[i]);
                    m = (v == PAT_T);
                end
            end
            expPulse = m;
            if (c) begin
                expCount = 0;
                expTrig  = 1'b0;
            end else if (m && expCount < THRESH_T) begin
                expCount++;
            end
            if (!c) expTrig = (expCount >= THRESH_T);
        end
    endtask

    // One clock: drive on the falling edge, model and compare after the rise.
    task automatic applyStimulus(input bit r, input bit e, input bit d, input bit c);
        @(negedge clk);
        rst = r;
        en  = e;
        din = d;
        clr = c;
        @(posedge clk);
        modelStep(r, e, d, c);
        #1;
        checkOutput("model_pulse", int'(pulseOut), int'(expPulse));
        checkOutput("model_trig",  int'(trigOut),  int'(expTrig));
        checkOutput("model_count", int'(countOut), expCount);
        if (pulseOut === 1'b1) pulseSeen++;
    endtask

    task automatic sendBits(input int n, input logic [15:0] bits);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, bits[i], 1'b0);
        end
    endtask

    task automatic doReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        end
    endtask

    initial begin
        // Reset then fill with zeros
        doReset(2);
        checkOutput("reset_pulse", int'(pulseOut), 0);
        checkOutput("reset_trig",  int'(trigOut),  0);
        checkOutput("reset_count", int'(countOut), 0);
        pulseSeen = 0;
        sendBits(4, 16'b0000);
        checkOutput("zero_fill_pulses", pulseSeen, 0);

        // Single match
        doReset(1);
        sendBits(4, 16'b1011);
        checkOutput("single_pulse", int'(pulseOut), 1);
        checkOutput("single_count", int'(countOut), 1);
        checkOutput("single_trig",  int'(trigOut),  0);

        // Overlapping matches up to the trigger, then saturation
        doReset(1);
        pulseSeen = 0;
        sendBits(10, 16'b1011011011);
        checkOutput("overlap_pulses", pulseSeen, 3);
        checkOutput("overlap_pulse",  int'(pulseOut), 1);
        checkOutput("overlap_count",  int'(countOut), 3);
        checkOutput("overlap_trig",   int'(trigOut),  1);
        sendBits(3, 16'b011);
        checkOutput("sat_pulse", int'(pulseOut), 1);
        checkOutput("sat_count", int'(countOut), 3);
        checkOutput("sat_trig",  int'(trigOut),  1);

        // Enable gaps: data toggles while disabled and must be ignored
        doReset(1);
        pulseSeen = 0;
        begin
            logic [3:0] gapBits;
            gapBits = 4'b1011;
            for (int i = 3; i >= 0; i--) begin
                applyStimulus(1'b0, 1'b1, gapBits[i], 1'b0);
                applyStimulus(1'b0, 1'b0, ~gapBits[i], 1'b0);
                applyStimulus(1'b0, 1'b0, ~gapBits[i], 1'b0);
            end
        end
        checkOutput("gap_pulses", pulseSeen, 1);
        checkOutput("gap_count",  int'(countOut), 1);

        // Clear colliding with a completing sample
        doReset(1);
        sendBits(7, 16'b1011011);
        checkOutput("pre_clear_count", int'(countOut), 2);
        sendBits(2, 16'b01);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("clear_pulse", int'(pulseOut), 1);
        checkOutput("clear_count", int'(countOut), 0);
        checkOutput("clear_trig",  int'(trigOut),  0);
        sendBits(3, 16'b011);
        checkOutput("post_clear_count", int'(countOut), 1);

        // Reset mid-run while FIRED, alongside a completing sample
        doReset(1);
        sendBits(10, 16'b1011011011);
        sendBits(2, 16'b01);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("midrst_pulse", int'(pulseOut), 0);
        checkOutput("midrst_trig",  int'(trigOut),  0);
        checkOutput("midrst_count", int'(countOut), 0);
        pulseSeen = 0;
        sendBits(3, 16'b011);
        checkOutput("midrst_nofill_pulses", pulseSeen, 0);
        checkOutput("midrst_nofill_count",  int'(countOut), 0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
